// File: rtl/baseball_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : baseball_pkg
//  Description : Shared constants and types for the scorekeeping stage:
//                hitout bit positions, base_runner state encoding and the
//                regulation-innings default.
//  Revision    : 1.0  initial release
// ============================================================================
package baseball_pkg;

  // Bit positions inside the roulette's one-hot hitout vector
  localparam int HIT1 = 4;
  localparam int HIT2 = 3;
  localparam int HIT3 = 2;
  localparam int HIT4 = 1;
  localparam int OUT  = 0;

  // Regulation length of a game and the hard extra-innings limit
  localparam int         INNINGS_DEFAULT = 9;
  localparam logic [3:0] MAX_INNING      = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_CHANGE = 2'd2,
    ST_OVER   = 2'd3
  } br_state_e;

  // Number of bases awarded by a hit; only meaningful when hitout is a hit
  function automatic logic [2:0] hit_bases(input logic [4:0] hitout);
    logic [2:0] n;
    n = 3'd4;
    if (hitout[HIT1])      n = 3'd1;
    else if (hitout[HIT2]) n = 3'd2;
    else if (hitout[HIT3]) n = 3'd3;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/runner_advance.sv
`default_nettype none
// ============================================================================
//  Module      : runner_advance
//  Description : Combinational runner movement for a hit of n_i bases.
//                The batter joins the occupancy vector as bit0, everything
//                shifts by n_i, and bits pushed past third base score.
//  Revision    : 1.0  initial release
// ============================================================================
module runner_advance
  import baseball_pkg::*;
(
  input  logic [2:0] bases_i,
  input  logic [2:0] n_i,
  output logic [2:0] bases_o,
  output logic [2:0] runs_o
);

  logic [7:0] shifted;

  // Shift batter plus runners, then split into new occupancy and runners home
  always_comb begin
    shifted = {4'b0000, bases_i, 1'b1} << n_i;
    bases_o = shifted[3:1];
    runs_o  = {2'b00, shifted[4]} + {2'b00, shifted[5]}
            + {2'b00, shifted[6]} + {2'b00, shifted[7]};
  end

endmodule
`default_nettype wire

// File: rtl/base_runner.sv
`default_nettype none
// ============================================================================
//  Module      : base_runner
//  Description : Scorekeeping stage behind the batting roulette. Samples the
//                one-hot hitout on each swing, advances runners, counts outs,
//                scores runs, changes sides and detects the end of the game.
//                Optional macro BASEBALL_WALKOFF_EN ends the game as soon as
//                the home side takes the lead in the bottom of a final inning.
//  Revision    : 1.0  initial release
// ============================================================================
module base_runner
  import baseball_pkg::*;
#(
  parameter int RUN_W   = 4,
  parameter int INNINGS = INNINGS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             swing_i,
  input  logic [4:0]       hitout_i,
  output logic             roulette_active_o,
  output logic [2:0]       bases_o,
  output logic [1:0]       outs_o,
  output logic [3:0]       inning_o,
  output logic             half_o,
  output logic [RUN_W-1:0] runs_away_o,
  output logic [RUN_W-1:0] runs_home_o,
  output logic             play_valid_o,
  output logic             game_over_o
);

  localparam int               SUM_W   = RUN_W + 3;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  br_state_e        state_q, state_d;
  logic [2:0]       bases_q, bases_d;
  logic [1:0]       outs_q, outs_d;
  logic [3:0]       inning_q, inning_d;
  logic             half_q, half_d;
  logic [RUN_W-1:0] away_q, away_d;
  logic [RUN_W-1:0] home_q, home_d;
  logic             pv_q, pv_d;

  logic             onehot;
  logic             swing_ok;
  logic             late_inning;
  logic [2:0]       adv_bases;
  logic [2:0]       adv_runs;
  logic [RUN_W-1:0] bat_runs;
  logic [SUM_W-1:0] bat_sum;
  logic [RUN_W-1:0] bat_sat;

  runner_advance u_advance (
    .bases_i (bases_q),
    .n_i     (hit_bases(hitout_i)),
    .bases_o (adv_bases),
    .runs_o  (adv_runs)
  );

  // Swing qualification and saturating score for the batting team
  always_comb begin
    onehot      = (hitout_i != 5'd0) && ((hitout_i & (hitout_i - 5'd1)) == 5'd0);
    swing_ok    = swing_i && (state_q == ST_PLAY) && onehot;
    late_inning = (inning_q >= 4'(INNINGS));
    bat_runs    = half_q ? home_q : away_q;
    bat_sum     = SUM_W'(bat_runs) + SUM_W'(adv_runs);
    bat_sat     = (bat_sum > SUM_W'(RUN_MAX)) ? RUN_MAX : bat_sum[RUN_W-1:0];
  end

  // Game FSM and scoreboard next-state
  always_comb begin
    state_d  = state_q;
    bases_d  = bases_q;
    outs_d   = outs_q;
    inning_d = inning_q;
    half_d   = half_q;
    away_d   = away_q;
    home_d   = home_q;
    pv_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_i) begin
          state_d  = ST_PLAY;
          bases_d  = 3'd0;
          outs_d   = 2'd0;
          inning_d = 4'd1;
          half_d   = 1'b0;
          away_d   = '0;
          home_d   = '0;
        end
      end
      ST_PLAY: begin
        if (swing_ok) begin
          pv_d = 1'b1;
          if (hitout_i[OUT]) begin
            if (outs_q == 2'd2) begin
              outs_d  = 2'd0;
              bases_d = 3'd0;
              state_d = ST_CHANGE;
            end else begin
              outs_d = outs_q + 2'd1;
            end
          end else begin
            bases_d = adv_bases;
            if (half_q) home_d = bat_sat;
            else        away_d = bat_sat;
`ifdef BASEBALL_WALKOFF_EN
            // Home takes the lead in a final inning: no need to finish it
            if (half_q && late_inning && (bat_sat > away_q)) state_d = ST_OVER;
`endif
          end
        end
      end
      ST_CHANGE: begin
        if (!half_q) begin
          if (late_inning && (home_q > away_q)) begin
            state_d = ST_OVER;
          end else begin
            half_d  = 1'b1;
            state_d = ST_PLAY;
          end
        end else begin
          if ((late_inning && (home_q != away_q)) || (inning_q == MAX_INNING)) begin
            state_d = ST_OVER;
          end else begin
            inning_d = inning_q + 4'd1;
            half_d   = 1'b0;
            state_d  = ST_PLAY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and scoreboard registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      bases_q  <= 3'd0;
      outs_q   <= 2'd0;
      inning_q <= 4'd1;
      half_q   <= 1'b0;
      away_q   <= '0;
      home_q   <= '0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bases_q  <= bases_d;
      outs_q   <= outs_d;
      inning_q <= inning_d;
      half_q   <= half_d;
      away_q   <= away_d;
      home_q   <= home_d;
      pv_q     <= pv_d;
    end
  end

  assign roulette_active_o = (state_q == ST_PLAY);
  assign game_over_o       = (state_q == ST_OVER);
  assign bases_o           = bases_q;
  assign outs_o            = outs_q;
  assign inning_o          = inning_q;
  assign half_o            = half_q;
  assign runs_away_o       = away_q;
  assign runs_home_o       = home_q;
  assign play_valid_o      = pv_q;

endmodule
`default_nettype wire

// File: tb/tb_base_runner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_base_runner
//  Description : Self-checking bench for base_runner. Stimulus queues the
//                expected scoreboard for each accepted swing; a monitor pops
//                and compares whenever play_valid is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_base_runner;

  localparam int         RUN_W = 4;
  localparam logic [4:0] H1 = 5'b10000;
  localparam logic [4:0] H2 = 5'b01000;
  localparam logic [4:0] H3 = 5'b00100;
  localparam logic [4:0] H4 = 5'b00010;
  localparam logic [4:0] HO = 5'b00001;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start_i = 1'b0;
  logic             swing_i = 1'b0;
  logic [4:0]       hitout_i = 5'd0;
  logic             roulette_active_o;
  logic [2:0]       bases_o;
  logic [1:0]       outs_o;
  logic [3:0]       inning_o;
  logic             half_o;
  logic [RUN_W-1:0] runs_away_o;
  logic [RUN_W-1:0] runs_home_o;
  logic             play_valid_o;
  logic             game_over_o;

  base_runner #(.RUN_W(RUN_W), .INNINGS(9)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_i           (start_i),
    .swing_i           (swing_i),
    .hitout_i          (hitout_i),
    .roulette_active_o (roulette_active_o),
    .bases_o           (bases_o),
    .outs_o            (outs_o),
    .inning_o          (inning_o),
    .half_o            (half_o),
    .runs_away_o       (runs_away_o),
    .runs_home_o       (runs_home_o),
    .play_valid_o      (play_valid_o),
    .game_over_o       (game_over_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] b;
    logic [1:0] o;
    logic [3:0] ra;
    logic [3:0] rh;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ea = 0;
  int   eh = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every play_valid must match the next queued expectation
  always @(negedge clk) begin
    if (reset_n && play_valid_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_play_valid: got play_valid=1, expected 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("play_bases", int'(bases_o), int'(e.b));
        check("play_outs", int'(outs_o), int'(e.o));
        check("play_runs_away", int'(runs_away_o), int'(e.ra));
        check("play_runs_home", int'(runs_home_o), int'(e.rh));
      end
    end
  end

  task automatic push(input logic [2:0] b, input logic [1:0] o);
    exp_t e;
    e.b  = b;
    e.o  = o;
    e.ra = ea[3:0];
    e.rh = eh[3:0];
    sb_q.push_back(e);
  endtask

  // Called at a falling edge; holds swing for exactly one rising edge
  task automatic sw(input logic [4:0] h);
    swing_i  = 1'b1;
    hitout_i = h;
    @(negedge clk);
    swing_i  = 1'b0;
    hitout_i = 5'd0;
  endtask

  task automatic hit(input logic [4:0] h, input logic [2:0] b);
    push(b, 2'd0);
    sw(h);
  endtask

  // Retire the side and wait out the CHANGE cycle
  task automatic three_outs(input logic [2:0] b);
    push(b, 2'd1); sw(HO);
    push(b, 2'd2); sw(HO);
    push(3'd0, 2'd0); sw(HO);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ea = 0;
    eh = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int halves;
    // ---------------- reset and idle ----------------
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_bases", int'(bases_o), 0);
    check("rst_outs", int'(outs_o), 0);
    check("rst_inning", int'(inning_o), 1);
    check("rst_half", int'(half_o), 0);
    check("rst_runs_away", int'(runs_away_o), 0);
    check("rst_runs_home", int'(runs_home_o), 0);
    check("rst_play_valid", int'(play_valid_o), 0);
    check("rst_game_over", int'(game_over_o), 0);
    check("rst_active", int'(roulette_active_o), 0);
    sw(H1);
    check("idle_swing_bases", int'(bases_o), 0);

    // ---------------- game 1: hits, invalid input, side change ----------------
    pulse_start();
    check("start_active", int'(roulette_active_o), 1);
    check("start_inning", int'(inning_o), 1);
    check("start_half", int'(half_o), 0);
    hit(H2, 3'b010);
    hit(H1, 3'b101);
    sw(5'b00000);
    sw(5'b10001);
    check("invalid_bases", int'(bases_o), 5);
    check("invalid_outs", int'(outs_o), 0);
    ea = 1; hit(H2, 3'b110);
    ea = 4; hit(H4, 3'b000);
    push(3'd0, 2'd1); sw(HO);
    push(3'd0, 2'd2); sw(HO);
    push(3'd0, 2'd0); sw(HO);
    check("change_active", int'(roulette_active_o), 0);
    check("change_half_old", int'(half_o), 0);
    sw(H4);  // lands in CHANGE and must be dropped
    check("after_change_half", int'(half_o), 1);
    check("after_change_active", int'(roulette_active_o), 1);
    check("after_change_inning", int'(inning_o), 1);
    check("after_change_runs_away", int'(runs_away_o), 4);
    check("after_change_bases", int'(bases_o), 0);
    hit(H1, 3'b001);
    // asynchronous reset in mid-game, checked before the next rising edge
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_bases", int'(bases_o), 0);
    check("async_rst_half", int'(half_o), 0);
    check("async_rst_runs_away", int'(runs_away_o), 0);
    check("async_rst_active", int'(roulette_active_o), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sw(H1);

    // ---------------- game 2: away wins 2-1 in regulation ----------------
    pulse_start();
    ea = 1; hit(H4, 3'b000);
    ea = 2; hit(H4, 3'b000);
    three_outs(3'd0);
    eh = 1; hit(H4, 3'b000);
    three_outs(3'd0);
    repeat (15) three_outs(3'd0);
    check("g2_inning", int'(inning_o), 9);
    check("g2_half", int'(half_o), 1);
    check("g2_not_over", int'(game_over_o), 0);
    three_outs(3'd0);
    check("g2_game_over", int'(game_over_o), 1);
    check("g2_over_active", int'(roulette_active_o), 0);
    sw(H1);
    pulse_start();
    check("restart_game_over", int'(game_over_o), 0);
    check("restart_inning", int'(inning_o), 1);
    check("restart_half", int'(half_o), 0);
    check("restart_runs_away", int'(runs_away_o), 0);
    check("restart_runs_home", int'(runs_home_o), 0);
    check("restart_active", int'(roulette_active_o), 1);

    // ---------------- game 3: walk-off situation ----------------
    ea = 1; hit(H4, 3'b000);
    ea = 2; hit(H4, 3'b000);
    ea = 3; hit(H4, 3'b000);
    three_outs(3'd0);
    eh = 1; hit(H4, 3'b000);
    eh = 2; hit(H4, 3'b000);
    eh = 3; hit(H4, 3'b000);
    three_outs(3'd0);
    repeat (15) three_outs(3'd0);
    check("g3_inning", int'(inning_o), 9);
    check("g3_half", int'(half_o), 1);
    hit(H3, 3'b100);
    eh = 4; hit(H1, 3'b001);
    check("walkoff_runs_home", int'(runs_home_o), 4);
`ifdef BASEBALL_WALKOFF_EN
    check("walkoff_game_over", int'(game_over_o), 1);
    check("walkoff_active", int'(roulette_active_o), 0);
`else
    check("no_walkoff_game_over", int'(game_over_o), 0);
    check("no_walkoff_active", int'(roulette_active_o), 1);
    three_outs(3'b001);
    check("no_walkoff_end_over", int'(game_over_o), 1);
`endif

    // ---------------- game 4: scoreless draw at the 15-inning limit ----------------
    pulse_start();
    halves = 0;
    while (!game_over_o && halves < 40) begin
      three_outs(3'd0);
      halves++;
    end
    check("draw_halves", halves, 30);
    check("draw_game_over", int'(game_over_o), 1);
    check("draw_inning", int'(inning_o), 15);
    check("draw_half", int'(half_o), 1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
